reaction_game_ctrl: RTL

Game controller for the reaction-time Tiny Tapeout design. It sequences the START/READY/PLAY/FINISH game and generates the 10 ms timebase and the pseudo-random start delay. It also drives the BCD digit pair that the dual seven-segment driver multiplexes. It sits between the `ui_in` push-button and the existing digit decoder/display path inside `tt_um_template`.

---
 rtl/reaction_game_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/reaction_game_ctrl.sv
// Reaction-time game controller: button sync, LFSR start delay, tick prescaler, BCD timer.
// Optional best-score memory shown in START is enabled by defining REACTION_BEST_EN.
module reaction_game_ctrl #(
   parameter int TICK_CYCLES     = 100000,
   parameter int MIN_DELAY_TICKS = 100,
   parameter int RAND_BITS       = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   output logic [3:0] tens,
   output logic [3:0] ones,
   output logic [1:0] state,
   output logic       go_led,
   output logic       done
);

   typedef enum logic [1:0] {S_START = 2'd0, S_READY = 2'd1, S_PLAY = 2'd2, S_FINISH = 2'd3} state_t;

   localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

   state_t        cur, cur_nxt;
   logic          sync1, sync2, sync3, press;
   logic [15:0]   lfsr, lfsr_nxt;
   logic [PW-1:0] presc, presc_nxt;
   logic [16:0]   delay, delay_nxt;
   logic [3:0]    tens_nxt, ones_nxt;
   logic          go_nxt, done_nxt, tick;
   logic [3:0]    start_tens, start_ones;

`ifdef REACTION_BEST_EN
   logic [7:0] best, best_nxt;
   assign start_tens = best[7:4];
   assign start_ones = best[3:0];
`else
   assign start_tens = 4'hF;
   assign start_ones = 4'hF;
`endif

   assign state    = cur;
   assign tick     = (presc == PW'(TICK_CYCLES - 1));
   assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

   // press is registered so that it is a clean one-cycle event from synchronized edges only
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         sync3  <= 1'b0;
         press  <= 1'b0;
         lfsr   <= 16'hACE1;
         presc  <= '0;
         delay  <= '0;
         cur    <= S_START;
         tens   <= 4'hF;
         ones   <= 4'hF;
         go_led <= 1'b0;
         done   <= 1'b0;
`ifdef REACTION_BEST_EN
         best   <= 8'hFF;
`endif
      end else begin
         sync1  <= btn;
         sync2  <= sync1;
         sync3  <= sync2;
         press  <= sync2 & ~sync3;
         lfsr   <= lfsr_nxt;
         presc  <= presc_nxt;
         delay  <= delay_nxt;
         cur    <= cur_nxt;
         tens   <= tens_nxt;
         ones   <= ones_nxt;
         go_led <= go_nxt;
         done   <= done_nxt;
`ifdef REACTION_BEST_EN
         best   <= best_nxt;
`endif
      end
   end

   always_comb begin
      cur_nxt   = cur;
      tens_nxt  = tens;
      ones_nxt  = ones;
      go_nxt    = go_led;
      done_nxt  = done;
      delay_nxt = delay;
      presc_nxt = tick ? '0 : presc + PW'(1);
`ifdef REACTION_BEST_EN
      best_nxt  = best;
`endif
      case (cur)
         S_START: begin
            tens_nxt = start_tens;
            ones_nxt = start_ones;
            if (press) begin
               delay_nxt = 17'(MIN_DELAY_TICKS) + 17'(lfsr[RAND_BITS-1:0]);
               presc_nxt = '0;
               tens_nxt  = 4'hF;
               ones_nxt  = 4'hF;
               cur_nxt   = S_READY;
            end
         end
         S_READY: begin
            if (press) begin
               // false start: code A is blanked by the decoder
               tens_nxt = 4'hA;
               ones_nxt = 4'hA;
               done_nxt = 1'b1;
               cur_nxt  = S_FINISH;
            end else if (tick) begin
               delay_nxt = delay - 17'd1;
               if (delay == 17'd1) begin
                  presc_nxt = '0;
                  tens_nxt  = 4'd0;
                  ones_nxt  = 4'd0;
                  go_nxt    = 1'b1;
                  cur_nxt   = S_PLAY;
               end
            end
         end
         S_PLAY: begin
            if (press) begin
               go_nxt   = 1'b0;
               done_nxt = 1'b1;
               cur_nxt  = S_FINISH;
`ifdef REACTION_BEST_EN
               if ({tens, ones} < best) best_nxt = {tens, ones};
`endif
            end else if (tick) begin
               if (tens == 4'd9 && ones == 4'd9) begin
                  go_nxt   = 1'b0;
                  done_nxt = 1'b1;
                  cur_nxt  = S_FINISH;
               end else if (ones == 4'd9) begin
                  ones_nxt = 4'd0;
                  tens_nxt = tens + 4'd1;
               end else begin
                  ones_nxt = ones + 4'd1;
               end
            end
         end
         S_FINISH: begin
            if (press) begin
               done_nxt = 1'b0;
               tens_nxt = start_tens;
               ones_nxt = start_ones;
               cur_nxt  = S_START;
            end
         end
         default: cur_nxt = S_START;
      endcase
   end

endmodule
